// File: rtl/lenet_host_sequencer.sv
// Host-side sequencer for the LeNet-5 accelerator: START/DONE handshake with a watchdog,
// then a buffered read-back of the class scores streamed to the host as valid/ready.
module lenet_host_sequencer #(
  parameter int INTERNAL_BITS  = 32,
  parameter int SRAM_ADDR_BITS = 16,
  parameter int RESULT_BASE    = 0,
  parameter int RESULT_COUNT   = 10,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      host_go,
  output logic                      host_busy,
  output logic                      host_done,
  output logic                      host_err,
  output logic                      ACC_START,
  input  logic                      ACC_DONE,
  output logic                      SRAM_CENA,
  output logic [SRAM_ADDR_BITS-1:0] SRAM_AA,
  input  logic [INTERNAL_BITS-1:0]  SRAM_QA,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INTERNAL_BITS-1:0]  out_data,
  output logic [3:0]                out_index,
  output logic                      out_last
);

  localparam int CNT_W = $clog2(RESULT_COUNT + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICK,
    S_WAIT,
    S_READ,
    S_FINISH
  } state_t;

  typedef struct packed {
    logic [INTERNAL_BITS-1:0] data;
    logic [3:0]               index;
  } entry_t;

  state_t            state_q, state_d;
  logic [WD_W-1:0]   wd_cnt;
  logic [CNT_W-1:0]  rd_cnt;
  logic              in_flight;
  logic [3:0]        rd_tag;
  entry_t            fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_cnt;
  entry_t            head;

  logic wd_hit, wd_expire, issue, pop, capture;

  assign wd_hit    = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign wd_expire = (state_q == S_WAIT) && !ACC_DONE && wd_hit;

  assign head      = fifo_mem[rd_ptr];
  assign out_valid = (fifo_cnt != 2'd0);
  assign out_data  = head.data;
  assign out_index = head.index;
  assign out_last  = out_valid && (head.index == 4'(RESULT_COUNT - 1));
  assign pop       = out_valid && out_ready;
  assign capture   = in_flight;

  // The slot freed by this cycle's pop counts as free, so out_ready=1 sustains one score per cycle.
  assign issue = (state_q == S_READ) && (rd_cnt < CNT_W'(RESULT_COUNT)) &&
                 ((fifo_cnt - 2'(pop) + 2'(in_flight)) < 2'd2);

  assign SRAM_CENA = !issue;
  assign SRAM_AA   = issue ? (SRAM_ADDR_BITS'(RESULT_BASE) + SRAM_ADDR_BITS'(rd_cnt))
                           : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    ACC_START = 1'b0;
    host_busy = 1'b1;
    host_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        host_busy = 1'b0;
        if (host_go) state_d = S_KICK;
      end
      S_KICK: begin
        ACC_START = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (ACC_DONE)    state_d = S_READ;
        else if (wd_hit) state_d = S_IDLE;
      end
      S_READ: begin
        if (pop && out_last) state_d = S_FINISH;
      end
      S_FINISH: begin
        host_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt   <= '0;
      host_err <= 1'b0;
    end else begin
      if (state_q == S_KICK)      wd_cnt <= '0;
      else if (state_q == S_WAIT) wd_cnt <= wd_cnt + 1'b1;

      if (state_q == S_IDLE && host_go) host_err <= 1'b0;
      else if (wd_expire)               host_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt    <= '0;
      in_flight <= 1'b0;
      rd_tag    <= '0;
    end else begin
      in_flight <= issue;
      if (state_q == S_KICK) rd_cnt <= '0;
      else if (issue) begin
        rd_cnt <= rd_cnt + 1'b1;
        rd_tag <= 4'(rd_cnt);
      end
    end
  end

  // NOTE: the two buffer entries are reset as well, because the head must read 0 out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= '0;
    end else if (state_q == S_KICK) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= '0;
    end else begin
      if (capture) begin
        fifo_mem[wr_ptr] <= '{data: SRAM_QA, index: rd_tag};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + 2'(capture) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_lenet_host_sequencer.sv
// Directed scoreboard bench: expected scores are queued when host_go is driven and
// compared on each out_valid/out_ready handshake; SRAM holds 100+addr at every address.
module tb_lenet_host_sequencer;

  typedef struct packed {
    logic        last;
    logic [3:0]  index;
    logic [31:0] data;
  } score_t;

  logic clk = 1'b0;
  logic rst, go, acc_done, ready, sel;
  always #5 clk = ~clk;

  logic        a_busy, a_done, a_err, a_start, a_cena, a_valid, a_last;
  logic [15:0] a_aa;
  logic [31:0] a_qa, a_data;
  logic [3:0]  a_index;
  logic        b_busy, b_done, b_err, b_start, b_cena, b_valid, b_last;
  logic [15:0] b_aa;
  logic [31:0] b_qa, b_data;
  logic [3:0]  b_index;

  logic        o_busy, o_done, o_err, o_start, o_cena, o_valid, o_last;
  logic [15:0] o_aa;
  logic [31:0] o_data;
  logic [3:0]  o_index;

  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_done  = sel ? b_done  : a_done;
  assign o_err   = sel ? b_err   : a_err;
  assign o_start = sel ? b_start : a_start;
  assign o_cena  = sel ? b_cena  : a_cena;
  assign o_aa    = sel ? b_aa    : a_aa;
  assign o_valid = sel ? b_valid : a_valid;
  assign o_data  = sel ? b_data  : a_data;
  assign o_index = sel ? b_index : a_index;
  assign o_last  = sel ? b_last  : a_last;

  function automatic logic [31:0] sram_val(input logic [15:0] a);
    return 32'(a) + 32'd100;
  endfunction

  always @(posedge clk) begin
    if (!a_cena) a_qa <= sram_val(a_aa);
    if (!b_cena) b_qa <= sram_val(b_aa);
  end

  lenet_host_sequencer #(
    .INTERNAL_BITS(32), .SRAM_ADDR_BITS(16), .RESULT_BASE(0),
    .RESULT_COUNT(10), .TIMEOUT_CYCLES(64)
  ) u_dut (
    .clk(clk), .rst(rst), .host_go(go & ~sel), .host_busy(a_busy), .host_done(a_done),
    .host_err(a_err), .ACC_START(a_start), .ACC_DONE(acc_done & ~sel), .SRAM_CENA(a_cena),
    .SRAM_AA(a_aa), .SRAM_QA(a_qa), .out_valid(a_valid), .out_ready(ready),
    .out_data(a_data), .out_index(a_index), .out_last(a_last)
  );

  lenet_host_sequencer #(
    .INTERNAL_BITS(32), .SRAM_ADDR_BITS(16), .RESULT_BASE(16'hFFFE),
    .RESULT_COUNT(4), .TIMEOUT_CYCLES(64)
  ) u_wrap (
    .clk(clk), .rst(rst), .host_go(go & sel), .host_busy(b_busy), .host_done(b_done),
    .host_err(b_err), .ACC_START(b_start), .ACC_DONE(acc_done & sel), .SRAM_CENA(b_cena),
    .SRAM_AA(b_aa), .SRAM_QA(b_qa), .out_valid(b_valid), .out_ready(ready),
    .out_data(b_data), .out_index(b_index), .out_last(b_last)
  );

  int     n_assert = 0;
  int     n_fail   = 0;
  score_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy/done/err/start"}, {o_busy, o_done, o_err, o_start}, 4'b0000);
    check({tag, " cena"},  o_cena,  1'b1);
    check({tag, " aa"},    o_aa,    16'h0000);
    check({tag, " valid"}, o_valid, 1'b0);
    check({tag, " head"},  {o_last, o_index, o_data}, 37'h0);
  endtask

  // done_dly < 0: ACC_DONE never comes. abort_after >= 0: reset after that many scores.
  task automatic run(input string tag, input int done_dly, input bit bp, input bit spur,
                     input int abort_after, input int n, input logic [15:0] base);
    int          cyc, kick_cyc, done_cyc, first_v_cyc, last_hs_cyc, fin_cyc;
    int          kicks, hs_n, rd_n, done_n, busy_wait, max_out;
    bit          finished, prev_stall, in_read;
    score_t      prev_head, got, exp;
    logic [15:0] a;
    kick_cyc = -1; done_cyc = -1; first_v_cyc = -1; last_hs_cyc = -1; fin_cyc = 0;
    kicks = 0; hs_n = 0; rd_n = 0; done_n = 0; busy_wait = 0; max_out = 0;
    finished = 0; prev_stall = 0; in_read = 0; prev_head = '0;

    if (done_dly >= 0)
      for (int i = 0; i < n; i++) begin
        a = base + 16'(i);
        exp_q.push_back('{last: (i == n - 1), index: 4'(i), data: sram_val(a)});
      end

    for (cyc = 0; cyc < 3000 && !(finished && cyc >= fin_cyc + 5); cyc++) begin
      @(negedge clk);
      if (abort_after >= 0 && hs_n == abort_after) begin
        go = 1'b0; acc_done = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_outputs({tag, " async_reset"});
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        return;
      end
      go       = (cyc == 0) || (spur && in_read);
      acc_done = (spur && in_read);
      if (kick_cyc >= 0 && done_dly >= 0 && cyc == kick_cyc + done_dly) begin
        acc_done = 1'b1;
        done_cyc = cyc;
      end
      ready = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      #1;

      if (o_start) begin
        kicks++;
        if (kick_cyc < 0) begin
          kick_cyc = cyc;
          check({tag, " err_cleared_at_kick"}, o_err, 1'b0);
        end
      end
      if (kick_cyc >= 0 && cyc > kick_cyc && o_busy) busy_wait++;
      if (!o_cena) begin
        a = base + 16'(rd_n);
        check({tag, " read_addr"}, o_aa, a);
        rd_n++;
      end
      if (rd_n - hs_n > max_out) max_out = rd_n - hs_n;
      if (prev_stall)
        check({tag, " head_held"}, {o_valid, o_last, o_index, o_data}, {1'b1, prev_head});
      if (o_valid && first_v_cyc < 0) begin
        first_v_cyc = cyc;
        check({tag, " first_valid_cycle"}, cyc, done_cyc + 3);
      end
      if (o_valid && ready) begin
        got = {o_last, o_index, o_data};
        if (exp_q.size() == 0) check({tag, " unexpected_score"}, got, 37'h0 - 1);
        else begin
          exp = exp_q.pop_front();
          check({tag, " score"}, got, exp);
        end
        if (!bp && hs_n > 0) check({tag, " back_to_back"}, cyc, last_hs_cyc + 1);
        last_hs_cyc = cyc;
        hs_n++;
      end
      prev_stall = o_valid && !ready;
      prev_head  = {o_last, o_index, o_data};
      if (o_done) begin
        done_n++;
        check({tag, " done_after_last"}, cyc, last_hs_cyc + 1);
      end
      in_read = (first_v_cyc >= 0) && (hs_n < n);
      if (!finished && kick_cyc >= 0 && cyc > kick_cyc && !o_busy) begin
        finished = 1;
        fin_cyc  = cyc;
      end
    end

    check({tag, " finished"},   finished, 1'b1);
    check({tag, " start_cycles"}, kicks, 1);
    check({tag, " reads"},      rd_n, (done_dly < 0) ? 0 : n);
    check({tag, " scores"},     hs_n, (done_dly < 0) ? 0 : n);
    check({tag, " host_done"},  done_n, (done_dly < 0) ? 0 : 1);
    check({tag, " host_err"},   o_err, (done_dly < 0) ? 1'b1 : 1'b0);
    check({tag, " occupancy_le3"}, (max_out <= 3), 1'b1);
    check({tag, " queue_drained"}, exp_q.size(), 0);
    if (done_dly < 0) check({tag, " watchdog_wait_cycles"}, busy_wait, 64);
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; acc_done = 1'b0; ready = 1'b0; sel = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    run("basic",        50, 0, 0, -1, 10, 16'h0000);
    run("backpressure", 50, 1, 0, -1, 10, 16'h0000);
    run("watchdog",     -1, 0, 0, -1, 10, 16'h0000);
    run("collision",    64, 0, 0, -1, 10, 16'h0000);
    run("abort",        50, 0, 0,  4, 10, 16'h0000);
    run("replay",       50, 0, 0, -1, 10, 16'h0000);
    sel = 1'b1;
    run("wrap",         20, 0, 1, -1,  4, 16'hFFFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
